// File: rtl/bsg_fifo_1r1w_rolly_mc_pkg.sv
// Shared types and helpers for the multi-channel rollback FIFO.
// Pointers are carried in a fixed 16-bit container. Only the low ptr_width(els_p) bits
// are ever non-zero, so els_p is limited to 2**15.
package bsg_fifo_1r1w_rolly_mc_pkg;

    localparam int rolly_ptr_max_w_lp = 16;

    typedef logic [rolly_ptr_max_w_lp-1:0] rolly_ptr_t;

    typedef struct packed {
        rolly_ptr_t rptr;
        rolly_ptr_t rcptr;
        rolly_ptr_t wptr;
        rolly_ptr_t wcptr;
    } rolly_ptrs_s;

    typedef enum logic [1:0] {
        e_wnone,
        e_enq,
        e_commit,
        e_drop
    } rolly_wop_e;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    // Adds a 0/1 increment modulo 2**pw.
    function automatic rolly_ptr_t ptr_add(input rolly_ptr_t p, input logic inc, input int pw);
        rolly_ptr_t mask;
        mask = (rolly_ptr_t'(1) << pw) - rolly_ptr_t'(1);
        return (p + rolly_ptr_t'(inc)) & mask;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_rolly_mc_ptrs.sv
// One channel of the rollback FIFO.
// Holds four pointers: read, retire checkpoint, write and commit checkpoint.
// Derives the empty, full and nothing-to-retire flags from them.
// Optional macro BSG_FIFO_ROLLY_MC_COUNT_EN builds the committed-unread count.
// When the macro is undefined, count_o is tied to zero.
module bsg_fifo_1r1w_rolly_mc_ptrs
    import bsg_fifo_1r1w_rolly_mc_pkg::*;
#(
    parameter  int els_p     = 8,
    localparam int lg_els_lp = $clog2(els_p),
    localparam int ptr_w_lp  = ptr_width(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enq_i,
    input  rolly_wop_e           wop_i,
    input  logic                 yumi_i,
    input  logic                 deq_i,
    input  logic                 roll_i,
    input  logic                 clr_i,
    output logic [lg_els_lp-1:0] rlow_o,
    output logic [lg_els_lp-1:0] wlow_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 rdone_o,
    output logic [ptr_w_lp-1:0]  count_o
);

    rolly_ptrs_s ptrs_q, ptrs_d;

    // Pointer jumps. clr beats drop, and drop beats commit/enq. roll ignores yumi.
    always_comb begin
        ptrs_d = ptrs_q;
        if (roll_i) begin
            ptrs_d.rptr = ptr_add(ptrs_q.rcptr, deq_i, ptr_w_lp);
        end else begin
            ptrs_d.rptr = ptr_add(ptrs_q.rptr, yumi_i, ptr_w_lp);
        end
        ptrs_d.rcptr = ptr_add(ptrs_q.rcptr, deq_i, ptr_w_lp);
        if (clr_i) begin
            ptrs_d.wptr  = ptr_add(ptrs_q.rptr, yumi_i, ptr_w_lp);
            ptrs_d.wcptr = ptr_add(ptrs_q.rptr, yumi_i, ptr_w_lp);
        end else begin
            case (wop_i)
                e_drop: begin
                    ptrs_d.wptr = ptrs_q.wcptr;
                end
                e_commit: begin
                    ptrs_d.wptr  = ptr_add(ptrs_q.wptr, enq_i, ptr_w_lp);
                    ptrs_d.wcptr = ptr_add(ptrs_q.wptr, enq_i, ptr_w_lp);
                end
                default: begin
                    ptrs_d.wptr = ptr_add(ptrs_q.wptr, enq_i, ptr_w_lp);
                end
            endcase
        end
    end

    // Pointer state. Reset discards the channel contents immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptrs_q <= '0;
        end else begin
            ptrs_q <= ptrs_d;
        end
    end

    assign rlow_o  = ptrs_q.rptr[lg_els_lp-1:0];
    assign wlow_o  = ptrs_q.wptr[lg_els_lp-1:0];
    assign empty_o = (ptrs_q.rptr == ptrs_q.wcptr);
    assign full_o  = (ptrs_q.rcptr[lg_els_lp-1:0] == ptrs_q.wptr[lg_els_lp-1:0])
                   & (ptrs_q.rcptr[lg_els_lp] != ptrs_q.wptr[lg_els_lp]);
    assign rdone_o = (ptrs_q.rcptr == ptrs_q.rptr);

`ifdef BSG_FIFO_ROLLY_MC_COUNT_EN
    assign count_o = ptr_w_lp'(ptrs_q.wcptr - ptrs_q.rptr);
`else
    assign count_o = '0;
`endif

endmodule

// File: rtl/bsg_fifo_1r1w_rolly_mc.sv
// Multi-channel rollback FIFO. chan_p logical FIFOs share one storage array.
// Writes are speculative until they are committed or dropped.
// Reads are speculative until they are retired or rolled back.
// Optional macro BSG_FIFO_ROLLY_MC_COUNT_EN enables count_o; it is zero otherwise.
module bsg_fifo_1r1w_rolly_mc
    import bsg_fifo_1r1w_rolly_mc_pkg::*;
#(
    parameter  int width_p            = 32,
    parameter  int els_p              = 8,
    parameter  int chan_p             = 4,
    parameter  int ready_THEN_valid_p = 0,
    localparam int lg_chan_lp         = (chan_p > 1) ? $clog2(chan_p) : 1,
    localparam int lg_els_lp          = $clog2(els_p),
    localparam int ptr_w_lp           = ptr_width(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [lg_chan_lp-1:0]      w_chan_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    input  logic                       commit_not_drop_v_i,
    input  logic                       commit_not_drop_i,
    input  logic [lg_chan_lp-1:0]      r_chan_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    input  logic                       deq_v_i,
    input  logic                       roll_v_i,
    input  logic                       clr_v_i,
    output logic [chan_p-1:0]          empty_o,
    output logic [chan_p*ptr_w_lp-1:0] count_o
);

    logic [chan_p-1:0]    full, empty, rdone;
    logic [lg_els_lp-1:0] rlow [chan_p];
    logic [lg_els_lp-1:0] wlow [chan_p];
    logic                 enq;

    // A clear on the write channel blocks new writes into that channel.
    assign ready_o = ~full[w_chan_i] & ~(clr_v_i & (r_chan_i == w_chan_i));
    assign enq     = (ready_THEN_valid_p != 0) ? v_i : (v_i & ready_o);
    assign v_o     = ~empty[r_chan_i] & ~roll_v_i;
    assign empty_o = empty;

    for (genvar c = 0; c < chan_p; c++) begin : g_chan
        logic                wsel, rsel;
        logic [ptr_w_lp-1:0] cnt;
        rolly_wop_e          wop;

        assign wsel = (w_chan_i == lg_chan_lp'(c));
        assign rsel = (r_chan_i == lg_chan_lp'(c));

        // Decode this channel's write-side checkpoint operation.
        always_comb begin
            wop = e_wnone;
            if (wsel & commit_not_drop_v_i) begin
                wop = commit_not_drop_i ? e_commit : e_drop;
            end else if (wsel & enq) begin
                wop = e_enq;
            end
        end

        bsg_fifo_1r1w_rolly_mc_ptrs #(.els_p(els_p)) ptrs (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .enq_i    (wsel & enq),
            .wop_i    (wop),
            .yumi_i   (rsel & yumi_i),
            .deq_i    (rsel & deq_v_i),
            .roll_i   (rsel & roll_v_i),
            .clr_i    (rsel & clr_v_i),
            .rlow_o   (rlow[c]),
            .wlow_o   (wlow[c]),
            .empty_o  (empty[c]),
            .full_o   (full[c]),
            .rdone_o  (rdone[c]),
            .count_o  (cnt)
        );

        assign count_o[c*ptr_w_lp +: ptr_w_lp] = cnt;
    end

    // Shared storage. Each channel owns one els_p-entry slice. Reads are combinational.
    logic [width_p-1:0]              mem_q [els_p*chan_p];
    logic [lg_chan_lp+lg_els_lp-1:0] waddr, raddr;

    assign waddr  = {w_chan_i, wlow[w_chan_i]};
    assign raddr  = {r_chan_i, rlow[r_chan_i]};
    assign data_o = mem_q[raddr];

    // Storage write. The array has no reset, and writes are held off while reset is low.
    always_ff @(posedge clk_i) begin
        if (enq & reset_n_i) begin
            mem_q[waddr] <= data_i;
        end
    end

`ifndef SYNTHESIS
    // Flag illegal use of the interface and unsupported configurations.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ((els_p & (els_p - 1)) == 0 && els_p >= 2 && els_p <= (1 << 15))
                else $error("els_p must be a power of two in 2..32768");
            assert (!(yumi_i && !v_o))
                else $error("yumi_i without v_o");
            assert (!(enq && full[w_chan_i]))
                else $error("enqueue into full channel");
            assert (!(deq_v_i && rdone[r_chan_i]))
                else $error("deq with nothing read to retire");
            assert (!(roll_v_i && yumi_i))
                else $error("roll together with yumi");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_mc.sv
// Directed testbench for bsg_fifo_1r1w_rolly_mc with default parameters (8 entries, 4 channels).
// The count_o expectations follow BSG_FIFO_ROLLY_MC_COUNT_EN; count_o must be zero when the macro is undefined.
module tb_bsg_fifo_1r1w_rolly_mc;

`ifdef BSG_FIFO_ROLLY_MC_COUNT_EN
    localparam bit count_en = 1'b1;
`else
    localparam bit count_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  w_chan, r_chan;
    logic        v, cnd_v, cnd, yumi, deq, roll, clr;
    logic [31:0] data;
    logic        ready, v_o;
    logic [31:0] data_o;
    logic [3:0]  empty;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bsg_fifo_1r1w_rolly_mc dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .w_chan_i           (w_chan),
        .v_i                (v),
        .data_i             (data),
        .ready_o            (ready),
        .commit_not_drop_v_i(cnd_v),
        .commit_not_drop_i  (cnd),
        .r_chan_i           (r_chan),
        .v_o                (v_o),
        .data_o             (data_o),
        .yumi_i             (yumi),
        .deq_v_i            (deq),
        .roll_v_i           (roll),
        .clr_v_i            (clr),
        .empty_o            (empty),
        .count_o            (count)
    );

    // Expected per-channel count, given the count feature build option.
    function automatic logic [3:0] cexp(input int n);
        return count_en ? 4'(n) : 4'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        v = 0; cnd_v = 0; cnd = 0; yumi = 0; deq = 0; roll = 0; clr = 0;
        data = '0;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d, input logic cm);
        w_chan = ch; data = d; v = 1; cnd_v = cm; cnd = 1;
        tick();
        v = 0; cnd_v = 0; cnd = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; v = 1; w_chan = 0; r_chan = 0; data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #2;
        total++; if (empty !== 4'hF) begin bad++; $display("[TB] FAIL rst_empty_held got=%h want=F", empty); end
        rst_n = 1; v = 0;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_v_o got=%b want=0", v_o); end
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%b want=1", ready); end
        total++; if (empty !== 4'hF) begin bad++; $display("[TB] FAIL rst_empty got=%h want=F", empty); end
        total++; if (count !== 16'h0) begin bad++; $display("[TB] FAIL rst_count got=%h want=0", count); end
        tick();
    endtask

    task automatic test_commit();
        push(2, 32'hA, 0);
        push(2, 32'hB, 0);
        r_chan = 2; #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL commit_pre_v_o got=%b want=0", v_o); end
        w_chan = 2; cnd_v = 1; cnd = 1;
        tick();
        idle(); #1;
        total++; if (v_o !== 1'b1) begin bad++; $display("[TB] FAIL commit_v_o got=%b want=1", v_o); end
        total++; if (data_o !== 32'hA) begin bad++; $display("[TB] FAIL commit_data got=%h want=A", data_o); end
        total++; if (count[11:8] !== cexp(2)) begin bad++; $display("[TB] FAIL commit_count got=%h want=%h", count[11:8], cexp(2)); end
        total++; if (empty !== 4'hB) begin bad++; $display("[TB] FAIL commit_empty got=%h want=B", empty); end
    endtask

    task automatic test_drop();
        push(1, 32'h1, 0);
        w_chan = 1; cnd_v = 1; cnd = 1; tick(); idle();
        push(1, 32'h2, 0);
        w_chan = 1; v = 1; data = 32'h3; cnd_v = 1; cnd = 0;
        tick();
        idle(); r_chan = 1; #1;
        total++; if (v_o !== 1'b1) begin bad++; $display("[TB] FAIL drop_v_o got=%b want=1", v_o); end
        total++; if (data_o !== 32'h1) begin bad++; $display("[TB] FAIL drop_data got=%h want=1", data_o); end
        total++; if (count[7:4] !== cexp(1)) begin bad++; $display("[TB] FAIL drop_count got=%h want=%h", count[7:4], cexp(1)); end
        yumi = 1; tick(); yumi = 0; #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL drop_after_read_v_o got=%b want=0", v_o); end
        deq = 1; tick(); deq = 0;
        w_chan = 1; cnd_v = 1; cnd = 1; tick(); idle(); #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL drop_recommit_v_o got=%b want=0", v_o); end
    endtask

    task automatic test_roll();
        push(0, 32'h1, 0);
        push(0, 32'h2, 0);
        push(0, 32'h3, 1);
        r_chan = 0; #1;
        total++; if (data_o !== 32'h1) begin bad++; $display("[TB] FAIL roll_head got=%h want=1", data_o); end
        yumi = 1; tick(); #1;
        total++; if (data_o !== 32'h2) begin bad++; $display("[TB] FAIL roll_second got=%h want=2", data_o); end
        tick(); yumi = 0;
        deq = 1; tick(); deq = 0;
        roll = 1; #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL roll_masks_v_o got=%b want=0", v_o); end
        tick(); roll = 0; #1;
        total++; if (v_o !== 1'b1) begin bad++; $display("[TB] FAIL roll_v_o got=%b want=1", v_o); end
        total++; if (data_o !== 32'h2) begin bad++; $display("[TB] FAIL roll_data got=%h want=2", data_o); end
        total++; if (count[3:0] !== cexp(2)) begin bad++; $display("[TB] FAIL roll_count got=%h want=%h", count[3:0], cexp(2)); end
        yumi = 1; tick();
        deq = 1; #1;
        total++; if (data_o !== 32'h3) begin bad++; $display("[TB] FAIL roll_replay got=%h want=3", data_o); end
        tick(); yumi = 0;
        tick(); deq = 0; #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL roll_drained got=%b want=0", v_o); end
    endtask

    task automatic test_full_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) push(3, 32'h30 + 32'(pass * 16 + i), (i == 7));
            w_chan = 3; #1;
            total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready pass=%0d got=%b want=0", pass, ready); end
            total++; if (count[15:12] !== cexp(8)) begin bad++; $display("[TB] FAIL full_count pass=%0d got=%h want=%h", pass, count[15:12], cexp(8)); end
            w_chan = 2; #1;
            total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL other_chan_ready pass=%0d got=%b want=1", pass, ready); end
            r_chan = 3;
            for (int i = 0; i < 8; i++) begin
                yumi = 1; deq = (i > 0); #1;
                total++; if (data_o !== 32'h30 + 32'(pass * 16 + i)) begin bad++; $display("[TB] FAIL wrap_data pass=%0d idx=%0d got=%h want=%h", pass, i, data_o, 32'h30 + 32'(pass * 16 + i)); end
                tick();
            end
            yumi = 0; deq = 1; tick(); deq = 0;
            w_chan = 3; #1;
            total++; if (empty[3] !== 1'b1 || ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_drained pass=%0d got=%b%b want=11", pass, empty[3], ready); end
        end
    endtask

    task automatic test_clr();
        push(1, 32'h11, 0);
        push(1, 32'h12, 0);
        push(1, 32'h13, 1);
        push(1, 32'h14, 0);
        push(1, 32'h15, 0);
        r_chan = 1; clr = 1; yumi = 1; w_chan = 1; #1;
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL clr_blocks_ready got=%b want=0", ready); end
        total++; if (data_o !== 32'h11) begin bad++; $display("[TB] FAIL clr_head got=%h want=11", data_o); end
        w_chan = 0; v = 1; data = 32'h55; cnd_v = 1; cnd = 1; #1;
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL clr_other_ready got=%b want=1", ready); end
        tick();
        idle(); #1;
        total++; if (empty !== 4'hA) begin bad++; $display("[TB] FAIL clr_empty got=%h want=A", empty); end
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL clr_v_o got=%b want=0", v_o); end
        total++; if (count[7:4] !== 4'd0) begin bad++; $display("[TB] FAIL clr_count got=%h want=0", count[7:4]); end
        r_chan = 0; #1;
        total++; if (v_o !== 1'b1 || data_o !== 32'h55) begin bad++; $display("[TB] FAIL clr_ch0 got=%b/%h want=1/55", v_o, data_o); end
        total++; if (count[3:0] !== cexp(1)) begin bad++; $display("[TB] FAIL clr_ch0_count got=%h want=%h", count[3:0], cexp(1)); end
        push(1, 32'h16, 1);
        r_chan = 1; #1;
        total++; if (v_o !== 1'b1 || data_o !== 32'h16) begin bad++; $display("[TB] FAIL clr_reuse got=%b/%h want=1/16", v_o, data_o); end
    endtask

    task automatic test_async_reset();
        r_chan = 0;
        rst_n = 0; #1;
        total++; if (empty !== 4'hF) begin bad++; $display("[TB] FAIL arst_empty got=%h want=F", empty); end
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL arst_v_o got=%b want=0", v_o); end
        total++; if (count !== 16'h0) begin bad++; $display("[TB] FAIL arst_count got=%h want=0", count); end
        #2; rst_n = 1;
        tick(); w_chan = 0; #1;
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL arst_ready got=%b want=1", ready); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_drop();
        test_roll();
        test_full_wrap();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
